ddram_responder: RTL and testbench



---
 rtl/ddram_responder.sv | 212 +++++++++++++++++++++
 tb/tb_ddram_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_responder.sv
// rtl/ddram_responder.sv - Block-RAM backed responder for the DDRAM_* port with programmable read latency.
// Optional: define DDRAM_RSP_STALL_EN for LFSR-driven BUSY stalls and read-data bubbles.
module ddram_responder #(
    parameter int          ADDR_W    = 10,
    parameter int          RD_LAT    = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        DDRAM_BUSY,
    input  logic [7:0]  DDRAM_BURSTCNT,
    input  logic [28:0] DDRAM_ADDR,
    input  logic        DDRAM_RD,
    input  logic        DDRAM_WE,
    input  logic [63:0] DDRAM_DIN,
    input  logic [7:0]  DDRAM_BE,
    output logic [63:0] DDRAM_DOUT,
    output logic        DDRAM_DOUT_READY
);
    typedef enum logic [1:0] {S_IDLE, S_WR_BURST, S_RD_LAT, S_RD_DATA} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [7:0]          len_q, len_d, beat_q, beat_d;
    logic [3:0]          lat_q, lat_d;
    logic                pend_vld_q, pend_vld_d, pend_we_q, pend_we_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [7:0]          pend_len_q, pend_len_d, pend_be_q, pend_be_d;
    logic [63:0]         pend_din_q, pend_din_d;
    logic                busy_q, busy_d, rdy_q, rdy_d;
    logic [63:0]         dout_q;

    logic [63:0]         mem_q [0:(1<<ADDR_W)-1];
    logic                rd_en, wr_en;
    logic [ADDR_W-1:0]   rd_addr, wr_addr;
    logic [63:0]         wr_data;
    logic [7:0]          wr_be;

    logic                accept, start, s_we, emit, stall_nxt;
    logic [ADDR_W-1:0]   s_addr;
    logic [7:0]          s_len, s_be, in_len;
    logic [63:0]         s_din;

    logic                unused_bits;
    assign unused_bits = ^{LFSR_SEED, DDRAM_ADDR[28:ADDR_W]};

    assign in_len = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
    assign accept = (DDRAM_RD | DDRAM_WE) & ~busy_q;

`ifdef DDRAM_RSP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall_nxt = (lfsr_d[1:0] == 2'b00);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign stall_nxt = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        beat_d      = beat_q;
        lat_d       = lat_q;
        pend_vld_d  = pend_vld_q;
        pend_we_d   = pend_we_q;
        pend_addr_d = pend_addr_q;
        pend_len_d  = pend_len_q;
        pend_be_d   = pend_be_q;
        pend_din_d  = pend_din_q;
        rdy_d       = 1'b0;
        busy_d      = 1'b1;
        rd_en       = 1'b0;
        rd_addr     = base_q + ADDR_W'(beat_q);
        wr_en       = 1'b0;
        wr_addr     = base_q + ADDR_W'(beat_q);
        wr_data     = DDRAM_DIN;
        wr_be       = DDRAM_BE;
        start       = 1'b0;
        s_we        = DDRAM_WE;
        s_addr      = DDRAM_ADDR[ADDR_W-1:0];
        s_len       = in_len;
        s_be        = DDRAM_BE;
        s_din       = DDRAM_DIN;
        emit        = 1'b0;

        case (state_q)
            S_IDLE: start = accept;
            S_WR_BURST: begin
                if (DDRAM_WE && !busy_q) begin
                    wr_en = 1'b1;
                    if (beat_q == len_q - 8'd1) state_d = S_IDLE;
                    else                        beat_d  = beat_q + 8'd1;
                end
            end
            S_RD_LAT: begin
                if (lat_q == 4'd0) begin
                    state_d = S_RD_DATA;
                    emit    = 1'b1;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_RD_DATA: begin
                if (beat_q == len_q) begin
                    // Last beat is on the bus now; a held command takes priority over a new one.
                    state_d = S_IDLE;
                    if (pend_vld_q) begin
                        start      = 1'b1;
                        s_we       = pend_we_q;
                        s_addr     = pend_addr_q;
                        s_len      = pend_len_q;
                        s_be       = pend_be_q;
                        s_din      = pend_din_q;
                        pend_vld_d = 1'b0;
                    end else begin
                        start = accept;
                    end
                end else begin
                    emit = 1'b1;
                    if (accept) begin
                        pend_vld_d  = 1'b1;
                        pend_we_d   = DDRAM_WE;
                        pend_addr_d = DDRAM_ADDR[ADDR_W-1:0];
                        pend_len_d  = in_len;
                        pend_be_d   = DDRAM_BE;
                        pend_din_d  = DDRAM_DIN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (emit && !stall_nxt) begin
            rdy_d  = 1'b1;
            rd_en  = 1'b1;
            beat_d = beat_q + 8'd1;
        end

        if (start) begin
            base_d = s_addr;
            len_d  = s_len;
            if (s_we) begin
                wr_en   = 1'b1;
                wr_addr = s_addr;
                wr_data = s_din;
                wr_be   = s_be;
                beat_d  = 8'd1;
                state_d = (s_len == 8'd1) ? S_IDLE : S_WR_BURST;
            end else begin
                beat_d  = 8'd0;
                lat_d   = 4'(RD_LAT - 1);
                state_d = S_RD_LAT;
            end
        end

        case (state_d)
            S_RD_LAT:  busy_d = 1'b1;
            S_RD_DATA: busy_d = pend_vld_d;
            default:   busy_d = stall_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_be[b]) mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= 8'd0;
            beat_q      <= 8'd0;
            lat_q       <= 4'd0;
            pend_vld_q  <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_len_q  <= 8'd0;
            pend_be_q   <= 8'd0;
            pend_din_q  <= 64'd0;
            busy_q      <= 1'b1;
            rdy_q       <= 1'b0;
            dout_q      <= 64'd0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            lat_q       <= lat_d;
            pend_vld_q  <= pend_vld_d;
            pend_we_q   <= pend_we_d;
            pend_addr_q <= pend_addr_d;
            pend_len_q  <= pend_len_d;
            pend_be_q   <= pend_be_d;
            pend_din_q  <= pend_din_d;
            busy_q      <= busy_d;
            rdy_q       <= rdy_d;
            if (rd_en) dout_q <= mem_q[rd_addr];
        end
    end

    assign DDRAM_BUSY       = busy_q;
    assign DDRAM_DOUT_READY = rdy_q;
    assign DDRAM_DOUT       = dout_q;
endmodule

// File: tb/tb_ddram_responder.sv
// tb/tb_ddram_responder.sv - Directed bench for ddram_responder with a memory/beat-schedule scoreboard.
module tb_ddram_responder;
    localparam int ADDR_W = 10;
    localparam int RD_LAT = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy, rdy;
    logic [63:0] dout;
    logic [7:0]  burstcnt = 8'd0;
    logic [28:0] addr = 29'd0;
    logic        rd = 1'b0, we = 1'b0;
    logic [63:0] din = 64'd0;
    logic [7:0]  be = 8'd0;

    ddram_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(burstcnt),
        .DDRAM_ADDR(addr), .DDRAM_RD(rd), .DDRAM_WE(we), .DDRAM_DIN(din), .DDRAM_BE(be),
        .DDRAM_DOUT(dout), .DDRAM_DOUT_READY(rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: plain word memory plus the schedule of read beats the client must see.
    logic [63:0] mdl [DEPTH];
    typedef struct { int cyc; logic [63:0] data; } beat_t;
    beat_t       expq[$];
    logic [63:0] obs[$];
    logic [63:0] last_dout = 64'd0;
    bit          chk_en = 1'b0;

    function automatic void mwrite(input int a, input logic [63:0] d, input logic [7:0] m);
        for (int b = 0; b < 8; b++) if (m[b]) mdl[a % DEPTH][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    function automatic logic [63:0] obs_back(input int k);
        if (obs.size() > k) return obs[obs.size() - 1 - k];
        return 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                chk("beat_ready", 64'(rdy), 64'd1);
                chk("beat_data", dout, expq[0].data);
                last_dout = expq[0].data;
                obs.push_back(dout);
                expq.delete(0);
            end else begin
                chk("idle_ready", 64'(rdy), 64'd0);
                chk("dout_hold", dout, last_dout);
            end
        end
    end

    task automatic wait_free();
        int k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) chk("busy_timeout", 64'(busy), 64'd0);
    endtask

    task automatic drain();
        int k = 0;
        while (expq.size() > 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("drain_empty", 64'(expq.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input logic [28:0] a, input int n, input logic [63:0] d0,
                            input logic [7:0] m, input int gap_at);
        int cnt = (n == 0) ? 1 : n;
        for (int i = 0; i < cnt; i++) begin
            wait_free();
            if (i == gap_at) @(negedge clk);
            we = 1'b1;
            din = d0 + 64'(i);
            be = m;
            addr = (i == 0) ? a : ~a;
            burstcnt = (i == 0) ? 8'(n) : 8'hFF;
            @(posedge clk);
            #1;
            we = 1'b0;
            mwrite(int'(a[ADDR_W-1:0]) + i, d0 + 64'(i), m);
        end
    endtask

    task automatic do_read(input logic [28:0] a, input int n, output int acc);
        int cnt = (n == 0) ? 1 : n;
        wait_free();
        rd = 1'b1;
        addr = a;
        burstcnt = 8'(n);
        @(posedge clk);
        #1;
        rd = 1'b0;
        acc = cyc;
        for (int i = 0; i < cnt; i++) begin
            beat_t b;
            b.cyc = acc + RD_LAT + i;
            b.data = mdl[(int'(a[ADDR_W-1:0]) + i) % DEPTH];
            expq.push_back(b);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int sz;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_ready", 64'(rdy), 64'd0);
        chk("rst_dout", dout, 64'd0);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_release", 64'(busy), 64'd0);

        // Single write/read, latency RD_LAT, upper address bits alias
        do_write(29'h0600_0010, 1, 64'h1122334455667788, 8'hFF, -1);
        do_read(29'h0600_0010, 1, n);
        chk("busy_in_rd_lat", 64'(busy), 64'd1);
        drain();
        chk("t1_data", obs_back(0), 64'h1122334455667788);
        do_read(29'h0000_0010, 1, n);
        drain();
        chk("alias_data", obs_back(0), 64'h1122334455667788);

        // Byte enables
        do_write(29'h020, 1, {16{4'hA}}, 8'hFF, -1);
        do_write(29'h020, 1, {16{4'h5}}, 8'h0F, -1);
        do_read(29'h020, 1, n);
        drain();
        chk("be_merge", obs_back(0), 64'hAAAAAAAA55555555);

        // Wrapping burst with an idle gap before beat 2
        do_write(29'h3FE, 4, 64'd1, 8'hFF, 2);
        do_read(29'h3FE, 4, n);
        drain();
        chk("wrap_b0", obs_back(3), 64'd1);
        chk("wrap_b1", obs_back(2), 64'd2);
        chk("wrap_b2", obs_back(1), 64'd3);
        chk("wrap_b3", obs_back(0), 64'd4);
        do_read(29'h000, 2, n);
        drain();
        chk("wrap_at0", obs_back(1), 64'd3);
        chk("wrap_at1", obs_back(0), 64'd4);

        // BURSTCNT=0 behaves as a single beat
        do_write(29'h051, 1, 64'h5151, 8'hFF, -1);
        do_write(29'h050, 0, 64'hC0FFEE, 8'hFF, -1);
        do_write(29'h060, 1, 64'h6060, 8'hFF, -1);
        do_read(29'h050, 0, n);
        drain();
        chk("cnt0_data", obs_back(0), 64'hC0FFEE);
        do_read(29'h051, 1, n);
        drain();
        chk("cnt0_no_spill", obs_back(0), 64'h5151);

        // RD and WE together: write wins, no read beats
        wait_free();
        rd = 1'b1; we = 1'b1; addr = 29'h070; din = 64'h7777; be = 8'hFF; burstcnt = 8'd1;
        @(posedge clk);
        #1;
        rd = 1'b0; we = 1'b0;
        mwrite(32'h070, 64'h7777, 8'hFF);
        sz = obs.size();
        repeat (8) @(negedge clk);
        chk("rdwe_no_beats", 64'(obs.size()), 64'(sz));
        do_read(29'h070, 1, n);
        drain();
        chk("rdwe_data", obs_back(0), 64'h7777);

        // Write arriving mid-read is held until the read finishes
        do_write(29'h100, 4, 64'd10, 8'hFF, -1);
        do_read(29'h100, 4, n);
        while (cyc < n + RD_LAT + 1) @(negedge clk);
        chk("busy_low_rd_data", 64'(busy), 64'd0);
        we = 1'b1; addr = 29'h101; din = 64'hDEAD_BEEF; be = 8'hFF; burstcnt = 8'd1;
        @(posedge clk);
        #1;
        we = 1'b0;
        mwrite(32'h101, 64'hDEAD_BEEF, 8'hFF);
        @(negedge clk);
        chk("pend_busy_a", 64'(busy), 64'd1);
        @(negedge clk);
        chk("pend_busy_b", 64'(busy), 64'd1);
        @(negedge clk);
        chk("pend_busy_end", 64'(busy), 64'd0);
        drain();
        chk("pend_old_data", obs_back(2), 64'd11);
        do_read(29'h101, 1, n);
        drain();
        chk("pend_new_data", obs_back(0), 64'hDEAD_BEEF);

        // Asynchronous reset in the middle of a read burst
        do_write(29'h200, 4, 64'h20, 8'hFF, -1);
        do_read(29'h200, 4, n);
        while (cyc < n + RD_LAT + 1) @(negedge clk);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(rdy), 64'd0);
        chk("arst_dout", dout, 64'd0);
        chk("arst_busy", 64'(busy), 64'd1);
        expq.delete();
        last_dout = 64'd0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_busy_release", 64'(busy), 64'd0);
        repeat (6) @(negedge clk);
        do_read(29'h201, 1, n);
        drain();
        chk("ram_kept", obs_back(0), 64'h21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
